ep3_in_arb: RTL
===============

EP3_IN_ARB -- requirements
Module: ep3_in_arb

Interface
REQ-001 Parameter ACK_TIMEOUT, default 7: cycles in WAIT_ACK before a commit is declared un-acked.
REQ-002 Parameter FLUSH_IDLE, default 256: owner-idle cycles before a partial-frame flush (only with EP3_ARB_FLUSH_EN).
REQ-003 Ports, in order:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- commit_len  in  11  frame length in bytes.
- ts_req  in  1  TS byte available.
- ts_data  in  8  TS byte.
- ts_gnt  out  1  TS byte taken this cycle.
- aux_req  in  1  aux/status byte available.
- aux_data  in  8  aux byte.
- aux_gnt  out  1  aux byte taken this cycle.
- ep3_usb_in_addr  out  11  buffer write address.
- ep3_usb_in_data  out  8  buffer write data.
- ep3_usb_in_wren  out  1  buffer write strobe.
- ep3_usb_in_commit  out  1  commit pulse.
- ep3_usb_in_ready  in  1  buffer ready.
- ep3_usb_in_commit_ack  in  1  commit acknowledge.
- ep3_usb_in_commit_len  out  11  committed length.
- owner  out  1  current frame owner (0=TS, 1=aux).
- missed  out  9  un-acked commit count.
- frames  out  16  committed frame count.

Function
REQ-004 FSM states IDLE, WRITE, COMMIT, WAIT_ACK; exactly one state active.
REQ-005 IDLE: when ep3_usb_in_ready=1 and a request is pending, latch owner and commit_len, then go to WRITE; otherwise stay.
REQ-006 Frame-level round robin: if both requesters are pending, the one not served in the last committed frame wins; after reset TS wins first.
REQ-007 Owner is fixed for the whole frame; the other requester's gnt stays 0.
REQ-008 In WRITE, gnt=owner_req AND ep3_usb_in_ready, combinational, same cycle.
REQ-009 One cycle after a gnt: wren=1 with the captured data and the current address; the address then increments.
REQ-010 Latency from gnt to wren is exactly 1 cycle; throughput is 1 byte per cycle.
REQ-011 The byte written at address latched_len-1 ends the frame: go to COMMIT; the address returns to 0.
REQ-012 Latched commit_len=0 is treated as 1; commit_len changes mid-frame are ignored until the next IDLE.
REQ-013 COMMIT: ep3_usb_in_commit=1 for exactly one cycle; ep3_usb_in_commit_len=frame byte count; then go to WAIT_ACK.
REQ-014 Commit_ack passes a two-flop synchronizer; a falling edge of the synchronized ack ends WAIT_ACK.
REQ-015 WAIT_ACK timeout: after ACK_TIMEOUT cycles without an ack falling edge, increment missed and return to IDLE.
REQ-016 Ack edge and timeout in the same cycle count as acked: missed is unchanged.
REQ-017 Leaving WAIT_ACK increments frames (wraps at 2^16) and records the served owner for round robin.
REQ-018 missed saturates at 511.
REQ-019 ep3_usb_in_ready falling mid-WRITE stalls gnt only; the frame resumes when ready returns.

Reset
REQ-020 Reset values: all outputs 0, state IDLE, address 0, missed 0, frames 0, round-robin pointer to TS.
REQ-021 Reset mid-frame abandons the frame: no commit, counters cleared, takes effect the next cycle.

Configuration
REQ-022 Macro EP3_ARB_FLUSH_EN, when defined: in WRITE with address>0 and no owner_req for FLUSH_IDLE consecutive cycles, go to COMMIT with ep3_usb_in_commit_len=address; the idle counter resets on every gnt.
REQ-023 Without EP3_ARB_FLUSH_EN: no flush logic; partial frames wait indefinitely; commit_len output always equals the latched length.

Structure
REQ-024 Package ep3_arb_pkg holds the state enum, owner codes (OWN_TS=0, OWN_AUX=1) and the 11-bit length width constant.
REQ-025 One sub-module, ep3_ack_sync: two-flop synchronizer plus falling-edge pulse.

Verification
REQ-026 commit_len=4, ts_req held high, ready=1 -> wren at addr 0..3, one commit with len 4, frames=1.
REQ-027 Both requesters high, commit_len=2 -> frames alternate TS, aux, TS; owner toggles per frame.
REQ-028 Ack never falls -> return to IDLE 7 cycles after entering WAIT_ACK; missed=1; 600 such frames -> missed=511.
REQ-029 Ready dropped for 5 cycles mid-frame, commit_len=8 -> no gnt during the drop; 8 contiguous addresses written; one commit.
REQ-030 With EP3_ARB_FLUSH_EN, commit_len=100, 3 bytes then idle -> commit with len 3 after 256 idle cycles.
REQ-031 Reset at addr 5 -> no commit; next frame starts at addr 0 and is owned by TS.

Source files
------------

// File: rtl/ep3_arb_pkg.sv
// ============================================================================
//  Module   : ep3_arb_pkg
//  Brief    : Shared types and constants for the EP3 IN-endpoint arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ep3_arb_pkg;

    localparam int   LEN_W   = 11;
    localparam logic OWN_TS  = 1'b0;
    localparam logic OWN_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    // A zero-length request still carries one byte.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ep3_ack_sync.sv
// ============================================================================
//  Module   : ep3_ack_sync
//  Brief    : Two-flop synchronizer for the commit acknowledge plus a
//             single-cycle falling-edge pulse on the synchronized level.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ep3_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ack,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_ack;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_fall = r_s2_d & ~r_s2;

endmodule

`default_nettype wire

// File: rtl/ep3_in_arb.sv
// ============================================================================
//  Module   : ep3_in_arb
//  Brief    : Frame-level round-robin arbiter writing TS / aux bytes into the
//             EP3 IN buffer, with commit / acknowledge handshake.
//             Optional partial-frame flush: define EP3_ARB_FLUSH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ep3_in_arb
    import ep3_arb_pkg::*;
#(
    parameter int ACK_TIMEOUT = 7,
    parameter int FLUSH_IDLE  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LEN_W-1:0] commit_len,
    input  logic             ts_req,
    input  logic [7:0]       ts_data,
    output logic             ts_gnt,
    input  logic             aux_req,
    input  logic [7:0]       aux_data,
    output logic             aux_gnt,
    output logic [LEN_W-1:0] ep3_usb_in_addr,
    output logic [7:0]       ep3_usb_in_data,
    output logic             ep3_usb_in_wren,
    output logic             ep3_usb_in_commit,
    input  logic             ep3_usb_in_ready,
    input  logic             ep3_usb_in_commit_ack,
    output logic [LEN_W-1:0] ep3_usb_in_commit_len,
    output logic             owner,
    output logic [8:0]       missed,
    output logic [15:0]      frames
);

    localparam int TO_W = $clog2(ACK_TIMEOUT) + 1;

    if (ACK_TIMEOUT < 1 || FLUSH_IDLE < 1) begin : g_param_check
        $error("ep3_in_arb: ACK_TIMEOUT and FLUSH_IDLE must be at least 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_pref;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_clen;
    logic [LEN_W-1:0] r_addr;
    logic [LEN_W-1:0] r_gcnt;
    logic             r_wren;
    logic [7:0]       r_wdata;
    logic [TO_W-1:0]  r_to;
    logic [8:0]       r_missed;
    logic [15:0]      r_frames;

    logic w_ack_fall;
    logic w_owner_req;
    logic w_gnt;
    logic w_next_owner;
    logic w_start;
    logic w_last_wr;
    logic w_timeout;
    logic w_leave;
    logic w_flush;

    ep3_ack_sync u_ack_sync (
        .clk    (clk),
        .rst    (reset),
        .i_ack  (ep3_usb_in_commit_ack),
        .o_fall (w_ack_fall)
    );

    assign w_owner_req  = (r_owner == OWN_AUX) ? aux_req : ts_req;
    // r_gcnt stops grants once the whole frame has been taken, while the
    // final byte is still one cycle away from its write.
    assign w_gnt        = (r_state == ST_WRITE) && w_owner_req && ep3_usb_in_ready
                          && (r_gcnt != r_len);
    assign w_next_owner = (ts_req && aux_req) ? r_pref : (aux_req ? OWN_AUX : OWN_TS);
    assign w_start      = (r_state == ST_IDLE) && ep3_usb_in_ready && (ts_req || aux_req);
    assign w_last_wr    = r_wren && (r_addr == r_len - LEN_W'(1));
    assign w_timeout    = (r_to == TO_W'(ACK_TIMEOUT - 1));
    assign w_leave      = (r_state == ST_WAIT_ACK) && (w_ack_fall || w_timeout);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_start) w_state_nxt = ST_WRITE;
            ST_WRITE:    if (w_last_wr || w_flush) w_state_nxt = ST_COMMIT;
            ST_COMMIT:   w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (w_leave) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= OWN_TS;
            r_pref   <= OWN_TS;
            r_len    <= '0;
            r_clen   <= '0;
            r_addr   <= '0;
            r_gcnt   <= '0;
            r_wren   <= 1'b0;
            r_wdata  <= '0;
            r_to     <= '0;
            r_missed <= '0;
            r_frames <= '0;
        end else begin
            if (w_start) begin
                r_owner <= w_next_owner;
                r_len   <= norm_len(commit_len);
                r_clen  <= norm_len(commit_len);
                r_gcnt  <= '0;
            end

            r_wren <= w_gnt;
            if (w_gnt) begin
                r_wdata <= (r_owner == OWN_AUX) ? aux_data : ts_data;
                r_gcnt  <= r_gcnt + LEN_W'(1);
            end

            if (r_wren) begin
                r_addr <= w_last_wr ? '0 : r_addr + LEN_W'(1);
            end

            if (w_flush) begin
                r_clen <= r_addr;
                r_addr <= '0;
            end

            if (r_state == ST_WAIT_ACK) begin
                r_to <= r_to + TO_W'(1);
            end else begin
                r_to <= '0;
            end

            if (w_leave) begin
                r_frames <= r_frames + 16'd1;
                r_pref   <= ~r_owner;
                // An ack edge landing on the timeout cycle still counts as acked.
                if (!w_ack_fall && r_missed != 9'h1FF) begin
                    r_missed <= r_missed + 9'd1;
                end
            end
        end
    end

`ifdef EP3_ARB_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_IDLE) + 1;

    logic [IDLE_W-1:0] r_idle;

    always_ff @(posedge clk) begin
        if (reset || r_state != ST_WRITE || w_gnt || w_owner_req) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(FLUSH_IDLE - 1)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    assign w_flush = (r_state == ST_WRITE) && !w_owner_req && !r_wren
                     && (r_addr != '0) && (r_idle == IDLE_W'(FLUSH_IDLE - 1));
`else
    assign w_flush = 1'b0;
`endif

    assign ts_gnt                = w_gnt && (r_owner == OWN_TS);
    assign aux_gnt               = w_gnt && (r_owner == OWN_AUX);
    assign ep3_usb_in_addr       = r_addr;
    assign ep3_usb_in_data       = r_wdata;
    assign ep3_usb_in_wren       = r_wren;
    assign ep3_usb_in_commit     = (r_state == ST_COMMIT);
    assign ep3_usb_in_commit_len = r_clen;
    assign owner                 = r_owner;
    assign missed                = r_missed;
    assign frames                = r_frames;

endmodule

`default_nettype wire
